// File: rtl/seq_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_div_ctrl
// Description : Multi-cycle restoring divider (DIV/DIVU), one quotient bit
//               per clock, with start/busy/done handshake and sign fix-up.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             step_sel
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_dd_neg;
    logic             w_dv_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_trial;

    // Most-negative input negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign w_dd_neg = is_signed & dividend[WIDTH-1];
    assign w_dv_neg = is_signed & divisor[WIDTH-1];
    assign w_abs_a  = w_dd_neg ? (~dividend + 1'b1) : dividend;
    assign w_abs_b  = w_dv_neg ? (~divisor + 1'b1) : divisor;

    assign w_trial  = {r_rem, r_q[WIDTH-1]} - {1'b0, r_b};
    assign step_sel = (r_state == S_ITER) & ~w_trial[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_b         <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_rem       <= '0;
                            r_q         <= w_abs_a;
                            r_b         <= w_abs_b;
                            r_neg_q     <= w_dd_neg ^ w_dv_neg;
                            r_neg_r     <= w_dd_neg;
                            r_count     <= '0;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            r_state     <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_rem   <= step_sel ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
                    r_q     <= {r_q[WIDTH-2:0], step_sel};
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient  <= r_neg_q ? (~r_q + 1'b1) : r_q;
                    remainder <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    r_state   <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_div_ctrl
// Description : Directed-vector bench for seq_div_ctrl (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        step_sel;

    int n_vec;
    int n_err;

    seq_div_ctrl #(.WIDTH(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .step_sel    (step_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one operation and follows it to done; inj_cyc >= 1 pulses a junk start in that cycle.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] dd,
                           input logic [31:0] dv, input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz, input int elat, input int esteps, input int inj_cyc);
        int cyc;
        int nb;
        int ns;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = dd;
        divisor   = dv;
        @(negedge clk);
        cyc = 1;
        nb  = 0;
        ns  = 0;
        start    = (cyc == inj_cyc);
        dividend = $urandom;
        divisor  = $urandom;
        while (!done && cyc < 200) begin
            if (busy) nb++;
            if (step_sel) ns++;
            @(negedge clk);
            cyc++;
            start = (cyc == inj_cyc);
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(elat));
        check({tag, " busy_cycles"}, 32'(nb), edbz ? 32'd0 : 32'(elat - 1));
        check({tag, " step_sel_ones"}, 32'(ns), 32'(esteps));
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset dbz", 32'(div_by_zero), 32'd0);
        check("reset step_sel", 32'(step_sel), 32'd0);
        rst = 1'b0;

        run_div("divu_100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34, 3, -1);
        run_div("div_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 34, 2, -1);
        run_div("div_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0, 34, 2, -1);
        run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 34, 3, -1);
        run_div("divu_5_0",    1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, 1,  0, -1);
        run_div("div_m8_0",    1'b1, 32'hFFFFFFF8,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF8,  1'b1, 1,  0, -1);
        run_div("div_ovf",     1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 34, 1, -1);
        run_div("divu_ovf",    1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 34, 0, -1);
        run_div("divu_ignore", 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34, 3, 10);

        // Results hold in IDLE after done.
        @(negedge clk);
        check("hold done", 32'(done), 32'd0);
        check("hold quotient", quotient, 32'd14);
        check("idle step_sel", 32'(step_sel), 32'd0);

        // Mid-operation reset at cycle 12.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_rst busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst quotient", quotient, 32'd0);
        check("rst remainder", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("divu_20_3",   1'b0, 32'd20,        32'd3,         32'd6,         32'd2,         1'b0, 34, 2, -1);

        // Back-to-back: second start lands in the IDLE cycle right after done.
        run_div("divu_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0, 34, 32, -1);
        run_div("divu_9_3",    1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0, 34, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
